execute_stage: RTL and testbench

//  Execute stage between instruction decode and memory access. Accepts decoded operands and control, then runs ALU, shift, iterative multiply or iterative divide.

---
 rtl/execute_stage_if.sv | 62 ++++++
 rtl/execute_stage.sv | 192 +++++++++++++++++++
 tb/tb_execute_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Execute stage port bundle: decode-side accept handshake,
// memory-side result handshake and forwarded control.
interface execute_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic             signed_mul;
  logic             left_shift;
  logic             arith_shift;
  logic             icc_we;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_c;
  logic [4:0]       rd_in;
  logic             reg_write_in;
  logic             mem_read_in;
  logic             mem_write_in;
  logic             mem_access_signed_in;
  logic [1:0]       mem_access_size_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] y_out;
  logic             icc_n;
  logic             icc_z;
  logic             icc_v;
  logic             icc_c;
  logic [WIDTH-1:0] store_data;
  logic [4:0]       rd;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             mem_access_signed;
  logic [1:0]       mem_access_size;

  modport master (
    output in_valid, alu_op, signed_mul, left_shift,
    output arith_shift, icc_we, src_a, src_b, src_c,
    output rd_in, reg_write_in, mem_read_in,
    output mem_write_in, mem_access_signed_in,
    output mem_access_size_in, out_ready,
    input  in_ready, out_valid, result, y_out,
    input  icc_n, icc_z, icc_v, icc_c, store_data,
    input  rd, reg_write, mem_read, mem_write,
    input  mem_access_signed, mem_access_size
  );

  modport slave (
    input  in_valid, alu_op, signed_mul, left_shift,
    input  arith_shift, icc_we, src_a, src_b, src_c,
    input  rd_in, reg_write_in, mem_read_in,
    input  mem_write_in, mem_access_signed_in,
    input  mem_access_size_in, out_ready,
    output in_ready, out_valid, result, y_out,
    output icc_n, icc_z, icc_v, icc_c, store_data,
    output rd, reg_write, mem_read, mem_write,
    output mem_access_signed, mem_access_size
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU/shift, iterative mul/div,
// ICC and Y update, valid/ready hand-off to memory stage.
module execute_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);
  localparam int W = WIDTH;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_DIV = 3'd5;
  localparam logic [2:0] OP_SHF = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic           fire, multi, last;
  logic [2:0]     op_q;
  logic [7:0]     cnt;
  logic           neg_q, icc_we_q;
  logic [W-1:0]   opb_q;
  logic [2*W-1:0] acc;

  assign bus.in_ready  = (state == IDLE) |
                         ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign fire  = bus.in_valid & bus.in_ready;
  assign multi = (bus.alu_op == OP_MUL) |
                 (bus.alu_op == OP_DIV);
  assign last  = cnt == ((op_q == OP_MUL) ?
                 8'(MUL_CYCLES - 1) : 8'(DIV_CYCLES - 1));

  logic [W-1:0] alu_res;
  logic         alu_v, alu_c;
  logic [W:0]   sum, dif;
  logic [4:0]   sh;

  // Single-cycle result and V/C straight from the inputs
  always_comb begin
    sum     = {1'b0, bus.src_a} + {1'b0, bus.src_b};
    dif     = {1'b0, bus.src_a} - {1'b0, bus.src_b};
    sh      = bus.src_b[4:0];
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (bus.alu_op)
      OP_AND: alu_res = bus.src_a & bus.src_b;
      OP_OR:  alu_res = bus.src_a | bus.src_b;
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (bus.src_a[W-1] == bus.src_b[W-1]) &
                  (sum[W-1] != bus.src_a[W-1]);
      end
      OP_SUB: begin
        alu_res = dif[W-1:0];
        alu_c   = dif[W];
        alu_v   = (bus.src_a[W-1] != bus.src_b[W-1]) &
                  (dif[W-1] != bus.src_a[W-1]);
      end
      OP_SHF: begin
        if (bus.left_shift)
          alu_res = bus.src_a << sh;
        else if (bus.arith_shift)
          alu_res = $signed(bus.src_a) >>> sh;
        else
          alu_res = bus.src_a >> sh;
      end
      default: alu_res = '0;
    endcase
  end

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nx, mul_fix, div_nx;
  logic [W:0]     div_rs;
  logic           div_ge;
  logic [W-1:0]   div_diff;

  // One shift-add / restoring-divide step on acc
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} +
               (acc[0] ? {1'b0, opb_q} : '0);
    mul_nx   = {mul_sum, acc[W-1:1]};
    mul_fix  = neg_q ? -mul_nx : mul_nx;
    div_rs   = {acc[2*W-1:W], acc[W-1]};
    div_ge   = div_rs >= {1'b0, opb_q};
    div_diff = div_rs[W-1:0] - opb_q;
    div_nx   = {div_ge ? div_diff : div_rs[W-1:0],
                acc[W-2:0], div_ge};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (fire) state_nx = multi ? BUSY : DONE;
      BUSY: if (last) state_nx = DONE;
      DONE: if (bus.out_ready)
              state_nx = fire ? (multi ? BUSY : DONE) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [W-1:0] a_mag, b_mag;
  assign a_mag = (bus.signed_mul & bus.src_a[W-1]) ?
                 -bus.src_a : bus.src_a;
  assign b_mag = (bus.signed_mul & bus.src_b[W-1]) ?
                 -bus.src_b : bus.src_b;

  // Operand latch, iteration, result/ICC/Y and forwarding
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;  cnt <= '0;  neg_q <= 1'b0;
      opb_q  <= '0;  acc <= '0;  icc_we_q <= 1'b0;
      bus.result <= '0;  bus.y_out <= '0;
      bus.icc_n  <= 1'b0; bus.icc_z <= 1'b0;
      bus.icc_v  <= 1'b0; bus.icc_c <= 1'b0;
      bus.store_data <= '0; bus.rd <= '0;
      bus.reg_write  <= 1'b0; bus.mem_read <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_access_signed <= 1'b0;
      bus.mem_access_size   <= '0;
    end else begin
      if (state == BUSY) begin
        cnt <= cnt + 8'd1;
        acc <= (op_q == OP_MUL) ? mul_nx : div_nx;
        if (last && op_q == OP_MUL) begin
          bus.result <= mul_fix[W-1:0];
          bus.y_out  <= mul_fix[2*W-1:W];
          if (icc_we_q) begin
            bus.icc_n <= mul_fix[W-1];
            bus.icc_z <= mul_fix[W-1:0] == '0;
            bus.icc_v <= 1'b0;
            bus.icc_c <= 1'b0;
          end
        end else if (last) begin
          bus.result <= div_nx[W-1:0];
          if (icc_we_q) begin
            bus.icc_n <= div_nx[W-1];
            bus.icc_z <= div_nx[W-1:0] == '0;
            bus.icc_v <= opb_q == '0;
            bus.icc_c <= 1'b0;
          end
        end
      end
      if (fire) begin
        op_q     <= bus.alu_op;
        icc_we_q <= bus.icc_we;
        cnt      <= '0;
        bus.store_data <= bus.src_c;
        bus.rd         <= bus.rd_in;
        bus.reg_write  <= bus.reg_write_in;
        bus.mem_read   <= bus.mem_read_in;
        bus.mem_write  <= bus.mem_write_in;
        bus.mem_access_signed <= bus.mem_access_signed_in;
        bus.mem_access_size   <= bus.mem_access_size_in;
        if (bus.alu_op == OP_MUL) begin
          neg_q <= bus.signed_mul &
                   (bus.src_a[W-1] ^ bus.src_b[W-1]);
          acc   <= {{W{1'b0}}, a_mag};
          opb_q <= b_mag;
        end else begin
          neg_q <= 1'b0;
          acc   <= {{W{1'b0}}, bus.src_a};
          opb_q <= bus.src_b;
        end
        if (!multi) begin
          bus.result <= alu_res;
          if (bus.icc_we) begin
            bus.icc_n <= alu_res[W-1];
            bus.icc_z <= alu_res == '0;
            bus.icc_v <= alu_v;
            bus.icc_c <= alu_c;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: arithmetic, shifts,
// mul/div latency, stall hold, back-to-back, reset abort.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_stage_if bus ();
  execute_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  wire [3:0] icc = {bus.icc_n, bus.icc_z, bus.icc_v, bus.icc_c};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input logic ls,
                       input logic ar, input logic ie,
                       input logic [4:0] rdv);
    bus.in_valid = 1'b1;
    bus.alu_op = op; bus.src_a = a; bus.src_b = b;
    bus.signed_mul = sm; bus.left_shift = ls;
    bus.arith_shift = ar; bus.icc_we = ie;
    bus.rd_in = rdv; bus.src_c = 32'h0;
    bus.reg_write_in = 1'b1; bus.mem_read_in = 1'b0;
    bus.mem_write_in = 1'b0; bus.mem_access_signed_in = 1'b0;
    bus.mem_access_size_in = 2'd0;
  endtask

  // Accept a multi-cycle op and count edges until out_valid
  task automatic run_multi(input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic sm, input logic ie,
                           output int n, output logic busy_rdy);
    drive(op, a, b, sm, 1'b0, 1'b0, ie, 5'd3);
    step;
    bus.in_valid = 1'b0;
    n = 1;
    busy_rdy = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready !== 1'b0) busy_rdy = 1'b1;
      step;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0",
               bus.in_ready, bus.out_valid);
    end
    total++;
    if (bus.result !== 32'h0 || bus.y_out !== 32'h0 || icc !== 4'h0) begin
      bad++;
      $display("FAIL reset_val got res=%h y=%h icc=%b exp 0",
               bus.result, bus.y_out, icc);
    end
    total++;
    if ({bus.store_data, bus.rd, bus.reg_write, bus.mem_read,
         bus.mem_write, bus.mem_access_signed,
         bus.mem_access_size} !== 43'h0) begin
      bad++;
      $display("FAIL reset_fwd got sd=%h rd=%0d exp 0",
               bus.store_data, bus.rd);
    end
  endtask

  task automatic test_add;
    drive(3'd2, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 1, 5'd5);
    bus.src_c = 32'hDEADBEEF;
    bus.mem_write_in = 1'b1;
    bus.mem_access_size_in = 2'd2;
    step;
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h80000000) begin
      bad++;
      $display("FAIL add_res got vld=%b res=%h exp vld=1 res=80000000",
               bus.out_valid, bus.result);
    end
    total++;
    if (icc !== 4'b1010) begin
      bad++;
      $display("FAIL add_icc got %b exp 1010", icc);
    end
    total++;
    if (bus.rd !== 5'd5 || bus.store_data !== 32'hDEADBEEF ||
        bus.mem_write !== 1'b1 || bus.mem_access_size !== 2'd2 ||
        bus.reg_write !== 1'b1) begin
      bad++;
      $display("FAIL add_fwd got rd=%0d sd=%h mw=%b sz=%0d",
               bus.rd, bus.store_data, bus.mem_write,
               bus.mem_access_size);
    end
    step;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_drain got vld=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_sub;
    drive(3'd3, 32'd5, 32'd5, 0, 0, 0, 1, 5'd1);
    step;
    bus.in_valid = 1'b0;
    total++;
    if (bus.result !== 32'h0 || icc !== 4'b0100) begin
      bad++;
      $display("FAIL sub_eq got res=%h icc=%b exp 0 0100",
               bus.result, icc);
    end
    step;
    drive(3'd3, 32'd3, 32'd5, 0, 0, 0, 1, 5'd1);
    step;
    bus.in_valid = 1'b0;
    total++;
    if (bus.result !== 32'hFFFFFFFE || icc !== 4'b1001) begin
      bad++;
      $display("FAIL sub_lt got res=%h icc=%b exp fffffffe 1001",
               bus.result, icc);
    end
    step;
  endtask

  task automatic test_logic;
    drive(3'd0, 32'hF0F00000, 32'h0FF00000, 0, 0, 0, 0, 5'd2);
    step;
    bus.in_valid = 1'b0;
    total++;
    if (bus.result !== 32'h00F00000 || icc !== 4'b1001) begin
      bad++;
      $display("FAIL and_hold got res=%h icc=%b exp 00f00000 1001",
               bus.result, icc);
    end
    step;
    drive(3'd1, 32'h000000F0, 32'h0F000000, 0, 0, 0, 1, 5'd2);
    step;
    bus.in_valid = 1'b0;
    total++;
    if (bus.result !== 32'h0F0000F0 || icc !== 4'b0000) begin
      bad++;
      $display("FAIL or got res=%h icc=%b exp 0f0000f0 0000",
               bus.result, icc);
    end
    step;
    drive(3'd7, 32'hFFFF, 32'hFFFF, 0, 0, 0, 1, 5'd17);
    step;
    bus.in_valid = 1'b0;
    total++;
    if (bus.result !== 32'h0 || icc !== 4'b0100 ||
        bus.rd !== 5'd17 || bus.reg_write !== 1'b1) begin
      bad++;
      $display("FAIL rsvd got res=%h icc=%b rd=%0d exp 0 0100 17",
               bus.result, icc, bus.rd);
    end
    step;
  endtask

  task automatic test_shift;
    logic [31:0] va [5] = '{32'h80000000, 32'h1, 32'h12345678,
                           32'h80000000, 32'hF0000001};
    logic [31:0] vb [5] = '{32'd4, 32'd31, 32'd0, 32'd4, 32'h24};
    logic        vl [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ve [5] = '{32'hF8000000, 32'h80000000,
                           32'h12345678, 32'h08000000,
                           32'hFF000000};
    logic [3:0]  ei;
    for (int i = 0; i < 5; i++) begin
      drive(3'd6, va[i], vb[i], 0, vl[i], vr[i], 1, 5'd4);
      step;
      bus.in_valid = 1'b0;
      ei = {ve[i][31], ve[i] == 32'h0, 2'b00};
      total++;
      if (bus.result !== ve[i] || icc !== ei) begin
        bad++;
        $display("FAIL shift%0d got res=%h icc=%b exp %h %b",
                 i, bus.result, icc, ve[i], ei);
      end
      step;
    end
  endtask

  task automatic test_mul;
    logic [31:0] va [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                           32'h00010000, 32'd2};
    logic [31:0] vb [5] = '{32'd5, 32'd2, 32'hFFFFFFFF,
                           32'h00010000, 32'hFFFFFFFD};
    logic        vs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vi [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] er [5] = '{32'hFFFFFFF1, 32'hFFFFFFFE, 32'h80000000,
                           32'h0, 32'hFFFFFFFA};
    logic [31:0] ey [5] = '{32'hFFFFFFFF, 32'h1, 32'h0,
                           32'h1, 32'hFFFFFFFF};
    logic [3:0]  ec [5] = '{4'b1000, 4'b1000, 4'b1000,
                           4'b0100, 4'b0100};
    int   n;
    logic br;
    for (int i = 0; i < 5; i++) begin
      run_multi(3'd4, va[i], vb[i], vs[i], vi[i], n, br);
      total++;
      if (n != 33 || br !== 1'b0) begin
        bad++;
        $display("FAIL mul%0d_lat got n=%0d rdy_busy=%b exp 33 0",
                 i, n, br);
      end
      total++;
      if (bus.result !== er[i] || bus.y_out !== ey[i] ||
          icc !== ec[i]) begin
        bad++;
        $display("FAIL mul%0d got res=%h y=%h icc=%b exp %h %h %b",
                 i, bus.result, bus.y_out, icc, er[i], ey[i], ec[i]);
      end
      step;
    end
  endtask

  task automatic test_div;
    logic [31:0] va [4] = '{32'd100, 32'd1234, 32'hFFFFFFFF, 32'd5};
    logic [31:0] vb [4] = '{32'd7, 32'd0, 32'd1, 32'd9};
    logic [31:0] er [4] = '{32'd14, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'd0};
    logic [3:0]  ec [4] = '{4'b0000, 4'b1010, 4'b1000, 4'b0100};
    int   n;
    logic br;
    for (int i = 0; i < 4; i++) begin
      run_multi(3'd5, va[i], vb[i], 1'b0, 1'b1, n, br);
      total++;
      if (n != 33 || br !== 1'b0) begin
        bad++;
        $display("FAIL div%0d_lat got n=%0d rdy_busy=%b exp 33 0",
                 i, n, br);
      end
      total++;
      if (bus.result !== er[i] || icc !== ec[i]) begin
        bad++;
        $display("FAIL div%0d got res=%h icc=%b exp %h %b",
                 i, bus.result, icc, er[i], ec[i]);
      end
      step;
    end
  endtask

  task automatic test_stall;
    bus.out_ready = 1'b0;
    drive(3'd2, 32'd1, 32'd2, 0, 0, 0, 0, 5'd9);
    step;
    drive(3'd3, 32'd10, 32'd1, 0, 0, 0, 0, 5'd10);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd3 ||
          bus.rd !== 5'd9 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d got vld=%b res=%h rd=%0d rdy=%b",
                 i, bus.out_valid, bus.result, bus.rd, bus.in_ready);
      end
      step;
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got rdy=%b exp 1", bus.in_ready);
    end
    step;
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd9 ||
        bus.rd !== 5'd10) begin
      bad++;
      $display("FAIL stall_next got vld=%b res=%h rd=%0d exp 1 9 10",
               bus.out_valid, bus.result, bus.rd);
    end
    step;
  endtask

  task automatic test_back_to_back;
    logic [31:0] va [4] = '{32'd1, 32'd100, 32'hFFFFFFFF, 32'h40000000};
    logic [31:0] vb [4] = '{32'd1, 32'd23, 32'd2, 32'h40000000};
    logic [31:0] ve [4] = '{32'd2, 32'd123, 32'd1, 32'h80000000};
    for (int i = 0; i < 4; i++) begin
      drive(3'd2, va[i], vb[i], 0, 0, 0, 0, 5'(i));
      step;
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== ve[i] ||
          bus.rd !== 5'(i)) begin
        bad++;
        $display("FAIL b2b%0d got vld=%b res=%h rd=%0d exp 1 %h %0d",
                 i, bus.out_valid, bus.result, bus.rd, ve[i], i);
      end
    end
    bus.in_valid = 1'b0;
    step;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got vld=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_rst_mid_div;
    logic seen;
    drive(3'd5, 32'd100, 32'd7, 0, 0, 0, 1, 5'd6);
    step;
    bus.in_valid = 1'b0;
    repeat (10) step;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rdiv_busy got vld=%b rdy=%b exp 0 0",
               bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.result !== 32'h0 || bus.y_out !== 32'h0 ||
        icc !== 4'h0 || bus.rd !== 5'd0) begin
      bad++;
      $display("FAIL rdiv_clr got rdy=%b vld=%b res=%h y=%h icc=%b rd=%0d",
               bus.in_ready, bus.out_valid, bus.result, bus.y_out,
               icc, bus.rd);
    end
    seen = 1'b0;
    repeat (40) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      step;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rdiv_noout got seen=%b exp 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0);
    bus.in_valid = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_shift;
    test_mul;
    test_div;
    test_stall;
    test_back_to_back;
    test_rst_mid_div;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
